cpu_state_dump: RTL and testbench

Hardware state-dump responder for the pipelined CPU. On request it streams a 44-word frame over a valid/ready interface: a header (cycle, stall and flush counts, PC), then all 32 architectural registers, then data-memory words 0x00–0x1C. The block sits beside the CPU core and reads through a spare register-file read port and a spare data-memory read port. It gives silicon and FPGA builds the same per-cycle visibility the simulation bench gets by hierarchical peeking.

---
 rtl/cpu_state_dump.sv | 168 ++++++++++++++++
 tb/tb_cpu_state_dump.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_state_dump.sv
// cpu_state_dump: streams a 44-word debug frame (header, regfile, dmem)
// over valid/ready; reads through spare regfile and dmem read ports.
module cpu_state_dump #(
  parameter int NUM_REGS = 32,
  parameter int NUM_MEM  = 8,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [31:0]       pc_i,
  input  logic              dump_req_i,
  output logic [4:0]        reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [31:0]       mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        out_tag_o,
  output logic              out_last_o,
  output logic              busy_o
);

  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    REG,
    MEM
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0]  idx, idx_nx;
  logic [DATA_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [DATA_W-1:0] hdr_cyc, hdr_stall, hdr_flush, hdr_pc;
  logic [DATA_W-1:0] data_nx, hdr_word;
  logic [1:0]        tag_nx;
  logic              valid_nx, last_nx, snap, load;

  assign busy_o = (state != IDLE);
  assign load   = !out_valid_o || out_ready_i;

  always_comb begin
    hdr_word = hdr_pc;
    case (idx[1:0])
      2'd0:    hdr_word = hdr_cyc;
      2'd1:    hdr_word = hdr_stall;
      2'd2:    hdr_word = hdr_flush;
      default: hdr_word = hdr_pc;
    endcase
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    valid_nx   = out_valid_o;
    data_nx    = out_data_o;
    tag_nx     = out_tag_o;
    last_nx    = out_last_o;
    snap       = 1'b0;
    reg_addr_o = 5'd0;
    mem_addr_o = 32'd0;
    unique case (state)
      IDLE: begin
        if (dump_req_i) begin
          state_nx = HDR;
          idx_nx   = '0;
          snap     = 1'b1;
        end
      end
      HDR: begin
        if (load) begin
          data_nx  = hdr_word;
          tag_nx   = 2'd0;
          last_nx  = 1'b0;
          valid_nx = 1'b1;
          if (idx == IDX_W'(3)) begin
            idx_nx   = '0;
            state_nx = REG;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      REG: begin
        reg_addr_o = idx[4:0];
        if (load) begin
          data_nx  = reg_data_i;
          tag_nx   = 2'd1;
          last_nx  = 1'b0;
          valid_nx = 1'b1;
          if (idx == IDX_W'(NUM_REGS - 1)) begin
            idx_nx   = '0;
            state_nx = MEM;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      MEM: begin
        mem_addr_o = {22'd0, idx, 2'b00};
        // final word is on the bus: wait for its acceptance, load nothing
        if (out_valid_o && out_last_o) begin
          if (out_ready_i) begin
            valid_nx = 1'b0;
            last_nx  = 1'b0;
            idx_nx   = '0;
            state_nx = IDLE;
          end
        end else if (load) begin
          data_nx  = mem_data_i;
          tag_nx   = 2'd2;
          valid_nx = 1'b1;
          last_nx  = (idx == IDX_W'(NUM_MEM - 1));
          if (idx != IDX_W'(NUM_MEM - 1)) begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      cycle_cnt   <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      hdr_cyc     <= '0;
      hdr_stall   <= '0;
      hdr_flush   <= '0;
      hdr_pc      <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_tag_o   <= 2'd0;
      out_last_o  <= 1'b0;
    end else begin
      if (start_i) begin
        cycle_cnt <= cycle_cnt + DATA_W'(1);
        if (stall_i) stall_cnt <= stall_cnt + DATA_W'(1);
        if (flush_i) flush_cnt <= flush_cnt + DATA_W'(1);
      end
      // header captures pre-increment counts for an atomic snapshot
      if (snap) begin
        hdr_cyc   <= cycle_cnt;
        hdr_stall <= stall_cnt;
        hdr_flush <= flush_cnt;
        hdr_pc    <= DATA_W'(pc_i);
      end
      state       <= state_nx;
      idx         <= idx_nx;
      out_valid_o <= valid_nx;
      out_data_o  <= data_nx;
      out_tag_o   <= tag_nx;
      out_last_o  <= last_nx;
    end
  end

endmodule

// File: tb/tb_cpu_state_dump.sv
// tb_cpu_state_dump: randomized frame checks of cpu_state_dump against
// a frame model built from counters, a regfile array and a dmem array.
module tb_cpu_state_dump;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic        dump_req_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic [1:0]  out_tag_o;
  logic        out_last_o;
  logic        busy_o;

  logic [31:0] regs [32];
  logic [31:0] mem  [8];
  logic [31:0] mc = 32'd0;
  logic [31:0] ms = 32'd0;
  logic [31:0] mf = 32'd0;
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [31:0] ref_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  cpu_state_dump dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .pc_i        (pc_i),
    .dump_req_i  (dump_req_i),
    .reg_addr_o  (reg_addr_o),
    .reg_data_i  (reg_data_i),
    .mem_addr_o  (mem_addr_o),
    .mem_data_i  (mem_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_tag_o   (out_tag_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  assign reg_data_i = regs[reg_addr_o];
  assign mem_data_i = (mem_addr_o < 32'd32) ? mem[mem_addr_o[4:2]] : 32'd0;

  always @(posedge clk_i) begin
    if (!rst_i) begin
      mc <= 32'd0;
      ms <= 32'd0;
      mf <= 32'd0;
    end else if (start_i) begin
      mc <= mc + 32'd1;
      if (stall_i) ms <= ms + 32'd1;
      if (flush_i) mf <= mf + 32'd1;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    dump_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic run_frame(input int pct, input bit fix,
                           input logic [31:0] f0, input logic [31:0] f1,
                           input logic [31:0] f2, input int abort_at,
                           input bit req_mid, input bit rnd_sf);
    int k;
    int cyc;
    bit hold;
    bit rdy;
    logic [31:0] sd;
    logic [1:0] st, et;
    logic sl;
    @(negedge clk_i);
    exp_q = {};
    exp_q.push_back(fix ? f0 : mc);
    exp_q.push_back(fix ? f1 : ms);
    exp_q.push_back(fix ? f2 : mf);
    exp_q.push_back(pc_i);
    for (int i = 0; i < 32; i++) exp_q.push_back(regs[i]);
    for (int i = 0; i < 8; i++) exp_q.push_back(mem[i]);
    got_q = {};
    dump_req_i = 1'b1;
    @(negedge clk_i);
    dump_req_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL accept busy=%b valid=%b want busy=1 valid=0",
               busy_o, out_valid_o);
    end
    k = 0;
    cyc = 0;
    hold = 0;
    sd = '0;
    st = '0;
    sl = 1'b0;
    while (k < 44) begin
      @(negedge clk_i);
      cyc++;
      if (cyc > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout words=%0d want 44", k);
        break;
      end
      if (rnd_sf) begin
        stall_i = $urandom_range(1);
        flush_i = $urandom_range(1);
      end
      if (abort_at >= 0 && k == abort_at) begin
        rst_i = 1'b0;
        break;
      end
      if (out_valid_o) begin
        n_cmp++;
        if (hold) begin
          if (out_data_o !== sd || out_tag_o !== st || out_last_o !== sl) begin
            n_bad++;
            $display("FAIL hold w%0d got %h/%0d/%b want %h/%0d/%b",
                     k, out_data_o, out_tag_o, out_last_o, sd, st, sl);
          end
        end else begin
          et = (k < 4) ? 2'd0 : ((k < 36) ? 2'd1 : 2'd2);
          got_q.push_back(out_data_o);
          if (out_data_o !== exp_q[k] || out_tag_o !== et ||
              out_last_o !== (k == 43)) begin
            n_bad++;
            $display("FAIL word%0d got %h/%0d/%b want %h/%0d/%b",
                     k, out_data_o, out_tag_o, out_last_o,
                     exp_q[k], et, (k == 43));
          end
          if (pct == 100 && (k == 0 || k == 43)) begin
            n_cmp++;
            if (cyc !== k + 1) begin
              n_bad++;
              $display("FAIL latency w%0d got edge %0d want %0d",
                       k, cyc, k + 1);
            end
          end
        end
      end
      rdy = ($urandom_range(99) < pct);
      out_ready_i = rdy;
      if (out_valid_o && rdy) begin
        k++;
        hold = 0;
      end else if (out_valid_o) begin
        hold = 1;
        sd = out_data_o;
        st = out_tag_o;
        sl = out_last_o;
      end
      dump_req_i = req_mid && (k >= 10) && (k < 13);
    end
    dump_req_i = 1'b0;
    @(negedge clk_i);
    if (abort_at >= 0) begin
      n_cmp++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || out_data_o !== 32'd0 ||
          out_last_o !== 1'b0 || out_tag_o !== 2'd0) begin
        n_bad++;
        $display("FAIL abort v=%b b=%b d=%h l=%b t=%0d want all 0",
                 out_valid_o, busy_o, out_data_o, out_last_o, out_tag_o);
      end
      rst_i = 1'b1;
    end else begin
      n_cmp++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        n_bad++;
        $display("FAIL end valid=%b busy=%b want 0/0", out_valid_o, busy_o);
      end
    end
    stall_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    fill_random();
    pc_i = 32'h0000_1234;
    do_reset();
    n_cmp++;
    if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || out_data_o !== 32'd0 ||
        out_tag_o !== 2'd0 || out_last_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out v=%b b=%b d=%h t=%0d l=%b want all 0",
               out_valid_o, busy_o, out_data_o, out_tag_o, out_last_o);
    end
    n_cmp++;
    if (reg_addr_o !== 5'd0 || mem_addr_o !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_addr ra=%0d ma=%h want 0/0", reg_addr_o, mem_addr_o);
    end
    run_frame(100, 1'b1, 32'd0, 32'd0, 32'd0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_counters();
    do_reset();
    pc_i = 32'h0000_0028;
    for (int i = 0; i < 20; i++) begin
      start_i = 1'b1;
      stall_i = (i == 3 || i == 7 || i == 11);
      flush_i = (i == 5 || i == 15);
      @(negedge clk_i);
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    run_frame(100, 1'b1, 32'd20, 32'd3, 32'd2, -1, 1'b0, 1'b0);
  endtask

  task automatic test_content();
    fill_random();
    regs[1] = 32'd5;
    regs[31] = 32'hFFFF_FFFF;
    mem[0] = 32'd5;
    mem[7] = 32'hA5A5_A5A5;
    run_frame(100, 1'b0, 32'd0, 32'd0, 32'd0, -1, 1'b0, 1'b0);
    n_cmp++;
    if (got_q.size() != 44 || got_q[5] !== 32'd5 ||
        got_q[35] !== 32'hFFFF_FFFF || got_q[36] !== 32'd5 ||
        got_q[43] !== 32'hA5A5_A5A5) begin
      n_bad++;
      $display("FAIL content n=%0d w5=%h w35=%h w36=%h w43=%h",
               got_q.size(), got_q.size() > 5 ? got_q[5] : 32'd0,
               got_q.size() > 35 ? got_q[35] : 32'd0,
               got_q.size() > 36 ? got_q[36] : 32'd0,
               got_q.size() > 43 ? got_q[43] : 32'd0);
    end
  endtask

  task automatic test_backpressure();
    bit same;
    fill_random();
    pc_i = $urandom;
    start_i = 1'b0;
    run_frame(100, 1'b0, 32'd0, 32'd0, 32'd0, -1, 1'b0, 1'b0);
    ref_q = got_q;
    run_frame(50, 1'b0, 32'd0, 32'd0, 32'd0, -1, 1'b0, 1'b0);
    same = (got_q.size() == ref_q.size());
    if (same) begin
      for (int i = 0; i < ref_q.size(); i++) begin
        if (got_q[i] !== ref_q[i]) same = 0;
      end
    end
    n_cmp++;
    if (!same) begin
      n_bad++;
      $display("FAIL bp_sequence got %0d words want %0d identical",
               got_q.size(), ref_q.size());
    end
  endtask

  task automatic test_busy_reset();
    fill_random();
    pc_i = $urandom;
    start_i = 1'b1;
    run_frame(100, 1'b0, 32'd0, 32'd0, 32'd0, 20, 1'b1, 1'b1);
    start_i = 1'b0;
    fill_random();
    run_frame(100, 1'b1, 32'd0, 32'd0, 32'd0, -1, 1'b0, 1'b0);
    start_i = 1'b1;
    run_frame(60, 1'b0, 32'd0, 32'd0, 32'd0, -1, 1'b0, 1'b1);
    start_i = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    pc_i = 32'hDEAD_BEEC;
    @(negedge clk_i);
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_cnt;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    run_frame(100, 1'b1, 32'd0, 32'd0, 32'd0, -1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    test_reset();
    test_counters();
    test_content();
    test_backpressure();
    test_busy_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
